// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 W-bit mux, bounded hold.
// Ports: clk, rst_n, req[3:0], I0..I3[W-1:0] in; gnt[3:0], s[1:0], o[W-1:0], valid out.
module mux4_rr_arbiter #(
    parameter int W        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] I0,
    input  logic [W-1:0] I1,
    input  logic [W-1:0] I2,
    input  logic [W-1:0] I3,
    output logic [3:0]   gnt,
    output logic [1:0]   s,
    output logic [W-1:0] o,
    output logic         valid
);

    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    logic           busy_q, busy_d;
    logic [1:0]     last_q, last_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [1:0]     s_q, s_d;
    logic [W-1:0]   o_q, o_d;
    logic           valid_q, valid_d;

    logic           arb;
    logic           win_found;
    logic [1:0]     win_idx;
    logic [1:0]     cand;
    logic [W-1:0]   sel_word;

    // Re-arbitrate when idle, when the owner let go, or on timeout.
    assign arb = !busy_q || !req[s_q] || (hold_cnt_q == HOLD_LAST);

    // Rotating search starting just after the most recent winner,
    // so the previous owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        busy_d     = busy_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        s_d        = s_q;
        if (arb) begin
            hold_cnt_d = '0;
            if (win_found) begin
                busy_d = 1'b1;
                s_d    = win_idx;
                last_d = win_idx;
                gnt_d  = 4'b0001 << win_idx;
            end else begin
                // s keeps its last value while idle.
                busy_d = 1'b0;
                gnt_d  = 4'b0000;
            end
        end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
        end
    end

    always_comb begin
        sel_word = '0;
        unique case (s_d)
            2'd0: sel_word = I0;
            2'd1: sel_word = I1;
            2'd2: sel_word = I2;
            2'd3: sel_word = I3;
            default: sel_word = '0;
        endcase
    end

    // Data and valid are taken from the next-state owner so that
    // o, gnt and valid all move on the same edge.
    always_comb begin
        valid_d = busy_d;
        o_d     = busy_d ? sel_word : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            last_q     <= 2'd3;
            hold_cnt_q <= '0;
            gnt_q      <= 4'b0000;
            s_q        <= 2'd0;
            o_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            s_q        <= s_d;
            o_q        <= o_d;
            valid_q    <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign s     = s_q;
    assign o     = o_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench for mux4_rr_arbiter.
// Reference model tracks owner / last winner / cycles held as integers.
module tb_mux4_rr_arbiter;

    localparam int W        = 4;
    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic [3:0]   gnt;
        logic [1:0]   s;
        logic [W-1:0] o;
        logic         valid;
    } obs_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] I0, I1, I2, I3;
    logic [3:0]   gnt;
    logic [1:0]   s;
    logic [W-1:0] o;
    logic         valid;

    int compared;
    int mismatched;

    obs_t sb[$];

    // Reference model state.
    int m_owner;   // -1 when idle
    int m_last;
    int m_held;    // cycles the current owner has held the mux
    int m_s;

    mux4_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .I0    (I0),
        .I1    (I1),
        .I2    (I2),
        .I3    (I3),
        .gnt   (gnt),
        .s     (s),
        .o     (o),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t cur_obs();
        obs_t r;
        r.gnt   = gnt;
        r.s     = s;
        r.o     = o;
        r.valid = valid;
        return r;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got gnt=%b s=%0d o=%h v=%b, want gnt=%b s=%0d o=%h v=%b",
                     name, act.gnt, act.s, act.o, act.valid,
                     exp.gnt, exp.s, exp.o, exp.valid);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_held  = 0;
        m_s     = 0;
    endtask

    // Predict the outputs after the coming edge from the current inputs.
    function automatic obs_t model_edge();
        obs_t e;
        int   words[4];
        bit   rearb;
        int   idx;
        words[0] = I0;
        words[1] = I1;
        words[2] = I2;
        words[3] = I3;
        rearb = (m_owner < 0) || !req[m_owner] || (m_held >= MAX_HOLD);
        if (rearb) begin
            m_owner = -1;
            m_held  = 0;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (m_owner < 0 && req[idx]) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_s     = idx;
                    m_held  = 1;
                end
            end
        end else begin
            m_held++;
        end
        e.s = 2'(m_s);
        if (m_owner >= 0) begin
            e.gnt   = 4'(1 << m_owner);
            e.o     = W'(words[m_owner]);
            e.valid = 1'b1;
        end else begin
            e.gnt   = 4'b0000;
            e.o     = '0;
            e.valid = 1'b0;
        end
        return e;
    endfunction

    // Called at a falling edge: apply inputs, predict, wait one cycle.
    task automatic step(input logic [3:0] r, input logic [W-1:0] d0,
                        input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input logic [W-1:0] d3);
        req = r;
        I0  = d0;
        I1  = d1;
        I2  = d2;
        I3  = d3;
        sb.push_back(model_edge());
        @(negedge clk);
    endtask

    task automatic rstep(input logic [3:0] r);
        step(r, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Monitor: compare every registered output update against the queue.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                check("edge", cur_obs(), e);
            end
        end
    end

    initial begin
        obs_t zero;
        compared   = 0;
        mismatched = 0;
        zero       = '0;
        model_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        I0    = 4'h1;
        I1    = 4'h2;
        I2    = 4'h3;
        I3    = 4'h4;

        repeat (3) begin
            @(negedge clk);
            check("reset_hold", cur_obs(), zero);
        end

        rst_n = 1'b1;
        step(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4);

        for (int i = 0; i < 10; i++)
            step(4'b0100, 4'h0, 4'h0, 4'hA, 4'h0);
        step(4'b0000, 4'h0, 4'h0, 4'hA, 4'h0);

        for (int i = 0; i < 20; i++)
            rstep(4'b1111);

        step(4'b0010, 4'h1, 4'h2, 4'h3, 4'h4);
        step(4'b1010, 4'h1, 4'h2, 4'h3, 4'h4);
        step(4'b1000, 4'h1, 4'h2, 4'h3, 4'h4);
        step(4'b0000, 4'h1, 4'h2, 4'h3, 4'h4);

        step(4'b0001, 4'h3, 4'h0, 4'h0, 4'h0);
        step(4'b0001, 4'h5, 4'h0, 4'h0, 4'h0);
        step(4'b0001, 4'h9, 4'h0, 4'h0, 4'h0);
        step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);

        for (int i = 0; i < 400; i++)
            rstep(4'($urandom));

        step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
        step(4'b0010, 4'h0, 4'h7, 4'h0, 4'h0);
        step(4'b0010, 4'h0, 4'h7, 4'h0, 4'h0);

        // Asynchronous reset between edges while requester 1 owns.
        rst_n = 1'b0;
        #1;
        check("async_reset", cur_obs(), zero);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_edge", cur_obs(), zero);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0110, 4'h0, 4'hB, 4'hC, 4'h0);

        for (int i = 0; i < 100; i++)
            rstep(4'($urandom));

        repeat (3) @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
